// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register with load-use hazard detection, EX-stage branch
// redirect to fetch, and saturating stall/flush debug counters.
module if_id_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  output logic             pc_write,
  output logic             branch_taken,
  output logic [31:0]      branch_addr,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_START,
    ST_ACTIVE
  } state_t;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH
  } mode_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  state_t            state_q, state_d;
  mode_t             mode;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [6:0]        opcode;
  logic [4:0]        rs1, rs2;
  logic              rs1_used, rs2_used;
  logic              load_use;

  always_comb begin
    opcode   = instr_q[6:0];
    rs1      = instr_q[19:15];
    rs2      = instr_q[24:20];
    rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    rs2_used = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
    load_use = valid_q && idex_mem_read && (idex_rd != 5'd0) &&
               ((rs1_used && (rs1 == idex_rd)) || (rs2_used && (rs2 == idex_rd)));
  end

  always_comb begin
    state_d      = ST_ACTIVE;
    mode         = MODE_IDLE;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    idex_bubble  = 1'b0;

    // Before the first post-reset edge everything idles so fetch holds its reset PC.
    if (state_q == ST_ACTIVE) begin
      if (ex_branch_taken)  mode = MODE_FLUSH;
      else if (load_use)    mode = MODE_STALL;
      else                  mode = MODE_RUN;
    end

    unique case (mode)
      MODE_FLUSH: begin
        branch_taken = 1'b1;
        branch_addr  = ex_branch_target;
        pc_write     = 1'b1;
        idex_bubble  = 1'b1;
        instr_d      = NOP_INSTR;
        pc_d         = '0;
        valid_d      = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      MODE_STALL: begin
        idex_bubble = 1'b1;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      MODE_RUN: begin
        pc_write = 1'b1;
        instr_d  = if_instr;
        pc_d     = if_pc;
        valid_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_START;
      instr_q     <= NOP_INSTR;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign id_instr  = instr_q;
  assign id_pc     = pc_q;
  assign id_valid  = valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
- Consumer-side partner of the instruction fetch stage in the 5-stage RV32I pipeline.
- Owns the IF/ID pipeline register and detects load-use hazards.
- Drives pc_write, branch_taken and branch_addr back into the fetch stage from EX-stage branch resolution.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- NOP_INSTR, 32'h00000013, instruction presented to ID on bubble/flush (addi x0,x0,0).
- CNT_W, 16, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_instr  in  32  instruction from the fetch stage.
- if_pc  in  32  PC of if_instr.
- ex_branch_taken  in  1  EX stage resolved a taken branch or jump this cycle.
- ex_branch_target  in  32  resolved target address.
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rd  in  5  destination register of the instruction in ID/EX.
- pc_write  out  1  fetch-stage PC update enable.
- branch_taken  out  1  redirect request to the fetch stage.
- branch_addr  out  32  redirect target.
- id_instr  out  32  IF/ID instruction register.
- id_pc  out  32  IF/ID PC register.
- id_valid  out  1  IF/ID holds a real instruction.
- idex_bubble  out  1  ID/EX must load a bubble next edge.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  branch flushes, saturating.

Behaviour:
- Reset (async, immediate):
  - id_instr=NOP_INSTR, id_pc=0, id_valid=0.
  - stall_cnt=0, flush_cnt=0, internal started=0.
  - pc_write=0, branch_taken=0, branch_addr=0, idex_bubble=0 while reset is high.
- Start-up: started sets on the first rising edge after reset deasserts. pc_write=0 until started=1, so the fetch stage holds its reset PC for exactly one cycle.
- Register-use decode on id_instr (opcode = bits[6:0]):
  - rs1 = [19:15] is used unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 = [24:20] is used only for R 0110011, S 0100011 and B 1100011.
- Hazard: load_use = id_valid & idex_mem_read & idex_rd!=0 & ((rs1 used & rs1==idex_rd) | (rs2 used & rs2==idex_rd)).
- Combinational outputs when started=1, in priority order:
  - FLUSH (ex_branch_taken=1):
    - branch_taken=1, branch_addr=ex_branch_target, pc_write=1, idex_bubble=1.
    - Next edge: id_instr=NOP_INSTR, id_valid=0, id_pc=0.
    - Branch priority overrides load_use.
  - STALL (load_use=1, no branch):
    - pc_write=0, branch_taken=0, idex_bubble=1.
    - IF/ID holds its value. Exactly one stall cycle per hazard: the next cycle the load has moved past ID/EX, so load_use deasserts.
  - RUN:
    - pc_write=1, branch_taken=0, idex_bubble=0.
    - Next edge: id_instr=if_instr, id_pc=if_pc, id_valid=1.
- branch_addr is 0 whenever branch_taken=0.
- Counters: stall_cnt +1 on each edge in STALL; flush_cnt +1 on each edge in FLUSH. Both saturate at all-ones and never wrap.
- Latency: an instruction fetched in cycle N appears on id_instr in cycle N+1 (RUN). A redirect is visible to the fetch stage in the same cycle ex_branch_taken asserts.
- Back-to-back branches: each cycle with ex_branch_taken flushes again and counts again.
- Reset mid-stall or mid-flush: everything returns to reset values asynchronously. No pending redirect survives reset.

Test Plan:
- Reset/start-up: reset high 2 cycles, then release -> pc_write=0 for one cycle, then 1; id_valid=0 until the first fetched instruction loads; id_instr=0x00000013 throughout reset.
- Straight-line flow: feed if_pc 0x0,0x4,0x8 with instrs 0x00500093, 0x00A00113, 0x002081B3 -> id_pc/id_instr follow one cycle later; id_valid=1; idex_bubble=0; stall_cnt=0.
- Load-use: id_instr=0x002081B3 (add x3,x1,x2), idex_mem_read=1, idex_rd=2 -> pc_write=0, idex_bubble=1, id_instr held one cycle, stall_cnt=1; same with idex_rd=0 -> no stall.
- Branch flush: ex_branch_taken=1, target 0x00000010 -> branch_taken=1, branch_addr=0x10, pc_write=1 same cycle; next edge id_valid=0, id_instr=0x00000013, flush_cnt=1.
- Simultaneous branch and load-use: both asserted -> FLUSH wins: pc_write=1, branch_taken=1; flush_cnt +1, stall_cnt unchanged.
- Reset mid-flush and saturation: assert reset while branch_taken=1 -> outputs 0 immediately. Separately, with CNT_W=4, 20 consecutive flushes -> flush_cnt=15 and holds.
